// File: rtl/data_mem_ctrl_pkg.sv
// Shared types, sizes and RV32I load/store funct3 encodings for the data-memory controller.
package data_mem_ctrl_pkg;

    localparam int unsigned DATA_WIDTH          = 32;
    localparam int unsigned DATA_MEM_DEPTH      = 1024;
    localparam int unsigned DATA_MEM_ADDR_WIDTH = 10;

    localparam logic [2:0] FUNCT3_LOAD_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LOAD_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LOAD_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LOAD_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LOAD_LHU = 3'd5;

    localparam logic [2:0] FUNCT3_STORE_SB = 3'd0;
    localparam logic [2:0] FUNCT3_STORE_SH = 3'd1;
    localparam logic [2:0] FUNCT3_STORE_SW = 3'd2;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_RESP   = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Pick the addressed byte/half out of a RAM word and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (funct3)
            FUNCT3_LOAD_LB:  load_extend = {{24{b[7]}}, b};
            FUNCT3_LOAD_LH:  load_extend = {{16{h[15]}}, h};
            FUNCT3_LOAD_LW:  load_extend = word;
            FUNCT3_LOAD_LBU: load_extend = {24'h0, b};
            FUNCT3_LOAD_LHU: load_extend = {16'h0, h};
            default:         load_extend = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_bram.sv
// Single-port synchronous RAM with byte write enables and a registered read port.
module data_mem_bram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes and read-before-write registered read; array is never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            for (int i = 0; i < int'(NB); i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory responder: one request per 3 cycles, fixed 2-cycle response latency.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = DATA_MEM_DEPTH,
    parameter int unsigned ADDR_W = DATA_MEM_ADDR_WIDTH,
    parameter int unsigned DATA_W = DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    mem_state_e  state_q, state_d;
    mem_req_t    req_q, req_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;

    logic        access_err_c;
    logic [3:0]  be_c;
    logic [3:0]  ram_be_c;
    logic        ram_en_c;
    logic [31:0] wdata_c;
    logic [31:0] ram_rdata;
    logic [31:0] load_data_c;
    logic [1:0]  off_c;
    logic        unused_addr_hi;

    assign off_c          = req_q.addr[1:0];
    assign unused_addr_hi = ^req_q.addr[31:ADDR_W+2];

    // Alignment/funct3 legality, store lane enables and lane-replicated store data.
    always_comb begin
        access_err_c = 1'b0;
        be_c         = 4'b0000;
        wdata_c      = req_q.wdata;
        if (req_q.we) begin
            case (req_q.funct3)
                FUNCT3_STORE_SB: begin
                    be_c    = 4'b0001 << off_c;
                    wdata_c = {4{req_q.wdata[7:0]}};
                end
                FUNCT3_STORE_SH: begin
                    be_c         = off_c[1] ? 4'b1100 : 4'b0011;
                    wdata_c      = {2{req_q.wdata[15:0]}};
                    access_err_c = off_c[0];
                end
                FUNCT3_STORE_SW: begin
                    be_c         = 4'b1111;
                    access_err_c = (off_c != 2'b00);
                end
                default: access_err_c = 1'b1;
            endcase
        end else begin
            case (req_q.funct3)
                FUNCT3_LOAD_LB, FUNCT3_LOAD_LBU: access_err_c = 1'b0;
                FUNCT3_LOAD_LH, FUNCT3_LOAD_LHU: access_err_c = off_c[0];
                FUNCT3_LOAD_LW:                  access_err_c = (off_c != 2'b00);
                default:                         access_err_c = 1'b1;
            endcase
        end
    end

    // RAM is touched only in ACCESS; a low reset at that edge suppresses the write.
    assign ram_en_c = (state_q == MEM_ACCESS) && rst_n;
    assign ram_be_c = (ram_en_c && req_q.we && !access_err_c) ? be_c : 4'b0000;

    data_mem_bram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en_c),
        .be    (ram_be_c),
        .addr  (req_q.addr[ADDR_W+1:2]),
        .wdata (wdata_c),
        .rdata (ram_rdata)
    );

    // Extended load data for the response; stores and errors return zero.
    assign load_data_c = (req_q.we || resp_err_q) ? 32'h0
                       : load_extend(req_q.funct3, off_c, ram_rdata);

    // Next-state, request latch and response-register updates.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        rdata_hold_d = rdata_hold_q;
        case (state_q)
            MEM_IDLE: begin
                if (req_valid) begin
                    req_d   = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                    state_d = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                resp_valid_d = 1'b1;
                resp_err_d   = access_err_c;
                state_d      = MEM_RESP;
            end
            MEM_RESP: begin
                rdata_hold_d = load_data_c;
                state_d      = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
        req_ready_d = (state_d == MEM_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MEM_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_hold_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = (state_q == MEM_RESP) ? load_data_c : rdata_hold_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Drive one request, wait for acceptance, and measure cycles until resp_valid (99 = timeout).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int w;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        lat = 99;
        rd  = 32'hxxxxxxxx;
        er  = 1'bx;
        if (req_ready) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                if (resp_valid) begin
                    lat = n;
                    rd  = resp_rdata;
                    er  = resp_err;
                    break;
                end
                if (n < 8) @(negedge clk);
            end
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL sw_resp: got rdata %h err %b expected 0/0", rd, er); end
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_word: got %h err %b expected deadbeef/0", rd, er); end
        @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b expected 0", resp_valid); end
        // Address bits above the word index wrap.
        do_req(1'b0, 3'd2, 32'h1010, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_wrap: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'd2, 32'h20, 32'h0, rd, er, lat);
        do_req(1'b1, 3'd0, 32'h21, 32'h12345680, rd, er, lat);
        n_checks++; if (er !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL sb_resp: got err %b lat %0d expected 0/2", er, lat); end
        do_req(1'b0, 3'd0, 32'h21, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sign: got %h expected ffffff80", rd); end
        do_req(1'b0, 3'd4, 32'h21, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zero: got %h expected 00000080", rd); end
        do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h00008000) begin n_fail++; $display("FAIL lw_after_sb: got %h expected 00008000", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'd2, 32'h30, 32'h0, rd, er, lat);
        do_req(1'b1, 3'd1, 32'h32, 32'hABCD1234, rd, er, lat);
        do_req(1'b0, 3'd1, 32'h32, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h00001234 || er !== 1'b0) begin n_fail++; $display("FAIL lh_hi: got %h err %b expected 00001234/0", rd, er); end
        do_req(1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h12340000) begin n_fail++; $display("FAIL lw_after_sh: got %h expected 12340000", rd); end
        do_req(1'b1, 3'd1, 32'h30, 32'h00008001, rd, er, lat);
        do_req(1'b0, 3'd1, 32'h30, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_sign: got %h expected ffff8001", rd); end
        do_req(1'b0, 3'd5, 32'h30, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu_zero: got %h expected 00008001", rd); end
        do_req(1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h12348001) begin n_fail++; $display("FAIL lw_two_halves: got %h expected 12348001", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'd2, 32'h40, 32'h11223344, rd, er, lat);
        do_req(1'b0, 3'd2, 32'h13, 32'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin n_fail++; $display("FAIL err_lw_mis: got err %b rdata %h lat %0d expected 1/0/2", er, rd, lat); end
        do_req(1'b0, 3'd1, 32'h11, 32'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_lh_mis: got err %b rdata %h expected 1/0", er, rd); end
        do_req(1'b1, 3'd2, 32'h42, 32'hCAFEF00D, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin n_fail++; $display("FAIL err_sw_mis: got err %b rdata %h lat %0d expected 1/0/2", er, rd, lat); end
        do_req(1'b0, 3'd3, 32'h40, 32'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_load_f3: got err %b rdata %h expected 1/0", er, rd); end
        do_req(1'b1, 3'd3, 32'h40, 32'hFFFFFFFF, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_store_f3: got err %b expected 1", er); end
        do_req(1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin n_fail++; $display("FAIL err_no_write: got %h err %b expected 11223344/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'd2, 32'h64, 32'h0, rd, er, lat);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'd2;
            req_addr   = 32'h60 + 32'(4 * i);
            req_wdata  = 32'h100 + 32'(i);
            n_checks++; if (req_ready !== ((i % 3) == 0)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, req_ready, (i % 3) == 0); end
            n_checks++; if (resp_valid !== ((i % 3) == 2)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, resp_valid, (i % 3) == 2); end
        end
        req_valid = 1'b0;
        do_req(1'b0, 3'd2, 32'h6C, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h103) begin n_fail++; $display("FAIL b2b_accepted: got %h expected 00000103", rd); end
        do_req(1'b0, 3'd2, 32'h64, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL b2b_ignored: got %h expected 00000000", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int seen;
        do_req(1'b1, 3'd2, 32'h50, 32'h55667788, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h50; req_wdata = 32'hAAAAAAAA;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 0;
        @(negedge clk);
        if (resp_valid) seen++;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_resp: got %0d pulses expected 0", seen); end
        do_req(1'b0, 3'd2, 32'h50, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h55667788) begin n_fail++; $display("FAIL midrst_no_write: got %h expected 55667788", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Multi-cycle data-memory responder serving the MEM-stage load/store initiator of the 5-stage RV32I core.
- Accepts one request per valid/ready handshake and performs byte, half or word access on an internal word-organised RAM with byte write enables.
- Returns sign/zero-extended load data, or a store completion, with an error flag.
- The core stalls on `req_ready=0` until `resp_valid`.

Parameters:
- `DEPTH`, default `DATA_MEM_DEPTH` (1024): number of 32-bit words.
- `ADDR_W`, default `DATA_MEM_ADDR_WIDTH` (10): word-index width; equals `$clog2(DEPTH)`.
- `DATA_W`, default `DATA_WIDTH` (32): data width.

Ports:
- `clk` in 1: clock; all logic rising-edge.
- `rst_n` in 1: synchronous reset, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_we` in 1: 1 = store (MemWrite), 0 = load (MemRead).
- `req_funct3` in 3: access size/sign; uses the FUNCT3_LOAD_* / FUNCT3_STORE_* encodings.
- `req_addr` in 32: byte address (alu_result).
- `req_wdata` in 32: store data (rd_data2); low bytes used for SB/SH.
- `resp_valid` out 1: one-cycle pulse, response valid.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal funct3; valid with `resp_valid`.

Behaviour:
- Reset (`rst_n=0` at edge): state←IDLE, `req_ready`=1 after reset, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. RAM contents are not reset.
- FSM states are IDLE, ACCESS and RESP.
  - IDLE → ACCESS on `req_valid`; request fields are latched at that edge.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- `req_ready`=1 only in IDLE. `req_valid` in other states is ignored and never queued.
- Latency: accept at edge of cycle T; RAM read/write occurs at edge of T+1; `resp_valid`=1 during T+2 only.
  - Fixed 2-cycle latency for all requests, errors included.
  - Maximum throughput is 1 request per 3 cycles.
- Word index = latched `addr[ADDR_W+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Error conditions (checked on latched fields in ACCESS):
  - halfword with `addr[0]=1`;
  - word with `addr[1:0]≠0`;
  - load funct3 ∈ {3,6,7};
  - store funct3 > 2.
- On error: no RAM write occurs, and `resp_err`=1 with `resp_rdata`=0.
- Store byte enables:
  - SB: lane `addr[1:0]`, data `wdata[7:0]` replicated to all lanes.
  - SH: lanes {1,0} or {3,2} by `addr[1]`, data `wdata[15:0]` replicated.
  - SW: all four lanes.
- Load: RAM read is synchronous. In RESP, select the byte/half by `addr[1:0]`, then extend:
  - LB/LH: sign-extend;
  - LBU/LHU: zero-extend;
  - LW: full word.
- Store response: `resp_valid`=1, `resp_rdata`=0, `resp_err`=0.
- Read-after-write: a load accepted after a store's `resp_valid` observes the stored data. No bypass is needed because accesses are serialised.
- Reset mid-operation: reset has priority.
  - A store in ACCESS with `rst_n=0` at that edge is not written.
  - A pending response is dropped and `resp_valid` stays 0.
- `resp_*` registers hold their last values outside RESP, except `resp_valid`, which is 0 outside RESP.

Decomposition:
- Shared package `core_pkg` additions:
  - `mem_state_e` enum {MEM_IDLE, MEM_ACCESS, MEM_RESP}, 2 bits;
  - `mem_req_t` packed struct {we, funct3, addr, wdata}.
- Existing FUNCT3_LOAD_*/STORE_* constants are reused.
- Sub-module `data_mem_bram`: single-port synchronous RAM, DEPTH×32, 4-bit byte write enable, registered read, no reset on the array.
- Alignment, error detection and extension stay in `data_mem_ctrl`.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0; `resp_valid` exactly 2 cycles after each accept.
- SB 0x80 @0x21, then LB @0x21 → 0xFFFFFF80; LBU @0x21 → 0x00000080; LW @0x20 → 0x00008000, assuming the word was 0 beforehand.
- SH 0x1234 @0x32, then LH @0x32 → 0x00001234; LW @0x30 → 0x12340000.
- LW @0x13, LH @0x11 and SW @0x42 → `resp_err`=1, `resp_rdata`=0; a subsequent LW @0x40 shows the word unchanged.
- `req_valid` held high continuously with distinct requests → `req_ready` pattern 1,0,0 repeating; only requests seen in IDLE are accepted.
- SW 0xAAAAAAAA @0x50 with `rst_n`=0 during ACCESS → no `resp_valid`; after reset, LW @0x50 returns the previous contents.
